// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage register file for the 16-bit pipelined CPU.
// Selects the writeback value from the MEM/WB register, commits it into a
// 16 x 16-bit array (R0 hardwired zero), serves two bypassed read ports,
// latches processor halt and counts committed register writes.
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic        PCtoReg,
    input  logic        Halt,
    input  logic [15:0] reg_data_in,
    input  logic [15:0] dmem_in,
    input  logic [3:0]  DstReg_in,
    input  logic [15:0] PC_in,
    input  logic [3:0]  SrcReg1,
    input  logic [3:0]  SrcReg2,
    output logic [15:0] SrcData1,
    output logic [15:0] SrcData2,
    output logic [15:0] WriteData,
    output logic        WriteEn,
    output logic        halted,
    output logic [15:0] write_count
);

    localparam int DATA_W = 16;
    localparam int IDX_W  = 4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  regs [0:(1<<IDX_W)-1];
    logic [DATA_W-1:0]  wcnt;

    // Read port: R0 is constant zero and never bypassed; an in-flight write
    // to the same index wins over the stored value.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [IDX_W-1:0]  idx,
        input logic [DATA_W-1:0] stored,
        input logic              wen,
        input logic [IDX_W-1:0]  dst,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] r;
        if (idx == '0)
            r = '0;
        else if (wen && (dst == idx))
            r = wdata;
        else
            r = stored;
        return r;
    endfunction

    // Halt state register; reset always returns to RUN.
    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_RUN;
        else
            state <= state_next;
    end

    // Halt next-state: RUN leaves on Halt, HALTED is sticky until reset.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (Halt) state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    // Writeback source select (PC beats memory beats ALU) and write qualify;
    // HLT itself never writes, nor does anything after it.
    always_comb begin
        WriteData = reg_data_in;
        if (PCtoReg)
            WriteData = PC_in;
        else if (MemtoReg)
            WriteData = dmem_in;
        WriteEn = RegWrite && !Halt && (state == ST_RUN) && (DstReg_in != '0);
    end

    // Register array and commit counter; reset clears both and wins over writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < (1 << IDX_W); i++)
                regs[i] <= '0;
            wcnt <= '0;
        end else if (WriteEn) begin
            regs[DstReg_in] <= WriteData;
            wcnt            <= wcnt + 16'd1;
        end
    end

    // Bypassed decode-stage read ports.
    always_comb begin
        SrcData1 = read_port(SrcReg1, regs[SrcReg1], WriteEn, DstReg_in, WriteData);
        SrcData2 = read_port(SrcReg2, regs[SrcReg2], WriteEn, DstReg_in, WriteData);
    end

    assign halted      = (state == ST_HALTED);
    assign write_count = wcnt;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scenario tasks for wb_regfile with an expected-value queue.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        RegWrite;
    logic        MemtoReg;
    logic        PCtoReg;
    logic        Halt;
    logic [15:0] reg_data_in;
    logic [15:0] dmem_in;
    logic [3:0]  DstReg_in;
    logic [15:0] PC_in;
    logic [3:0]  SrcReg1;
    logic [3:0]  SrcReg2;
    logic [15:0] SrcData1;
    logic [15:0] SrcData2;
    logic [15:0] WriteData;
    logic        WriteEn;
    logic        halted;
    logic [15:0] write_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] e;

    wb_regfile dut (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .PCtoReg(PCtoReg), .Halt(Halt), .reg_data_in(reg_data_in),
        .dmem_in(dmem_in), .DstReg_in(DstReg_in), .PC_in(PC_in),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .SrcData1(SrcData1),
        .SrcData2(SrcData2), .WriteData(WriteData), .WriteEn(WriteEn),
        .halted(halted), .write_count(write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rw, input logic m2r, input logic p2r, input logic hlt,
                         input logic [15:0] rd, input logic [15:0] dm, input logic [15:0] pc,
                         input logic [3:0] dst, input logic [3:0] s1, input logic [3:0] s2);
        RegWrite = rw; MemtoReg = m2r; PCtoReg = p2r; Halt = hlt;
        reg_data_in = rd; dmem_in = dm; PC_in = pc;
        DstReg_in = dst; SrcReg1 = s1; SrcReg2 = s2;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(1, 0, 0, 1, 16'hDEAD, 16'h0, 16'h0, 4'd5, 4'd5, 4'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); n_checks++;
        if ({15'd0, halted} !== e) begin n_fail++; $display("FAIL reset_halted: got %h expected %h", halted, e); end
        e = exp_q.pop_front(); n_checks++;
        if (write_count !== e) begin n_fail++; $display("FAIL reset_count: got %h expected %h", write_count, e); end
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            SrcReg1 = 4'(i);
            SrcReg2 = 4'(15 - i);
            exp_q.push_back(16'h0000);
            exp_q.push_back(16'h0000);
            @(negedge clk);
            e = exp_q.pop_front(); n_checks++;
            if (SrcData1 !== e) begin n_fail++; $display("FAIL reset_read1 r%0d: got %h expected %h", i, SrcData1, e); end
            e = exp_q.pop_front(); n_checks++;
            if (SrcData2 !== e) begin n_fail++; $display("FAIL reset_read2 r%0d: got %h expected %h", 15 - i, SrcData2, e); end
        end
    endtask

    task automatic test_bypass;
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 16'h1234, 16'h0, 16'h0, 4'd3, 4'd3, 4'd4);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", SrcData1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (SrcData2 !== e) begin n_fail++; $display("FAIL bypass_other_index: got %h expected %h", SrcData2, e); end
        e = exp_q.pop_front(); n_checks++;
        if ({15'd0, WriteEn} !== e) begin n_fail++; $display("FAIL bypass_wen: got %h expected %h", WriteEn, e); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 16'h9999, 16'h0, 16'h0, 4'd3, 4'd3, 4'd3);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h0001);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL stored_read: got %h expected %h", SrcData1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (write_count !== e) begin n_fail++; $display("FAIL count_after_one: got %h expected %h", write_count, e); end
    endtask

    task automatic test_source_select;
        @(posedge clk); #1;
        drive(1, 1, 0, 0, 16'h1111, 16'hBEEF, 16'h2222, 4'd5, 4'd0, 4'd0);
        exp_q.push_back(16'hBEEF);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (WriteData !== e) begin n_fail++; $display("FAIL sel_mem: got %h expected %h", WriteData, e); end
        @(posedge clk); #1;
        drive(1, 1, 1, 0, 16'h1111, 16'hBEEF, 16'h0042, 4'd6, 4'd0, 4'd0);
        exp_q.push_back(16'h0042);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (WriteData !== e) begin n_fail++; $display("FAIL sel_pc_wins: got %h expected %h", WriteData, e); end
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 16'hFFFF, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({15'd0, WriteEn} !== e) begin n_fail++; $display("FAIL r0_wen: got %h expected %h", WriteEn, e); end
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL r0_no_bypass: got %h expected %h", SrcData1, e); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd5, 4'd6);
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'h0042);
        exp_q.push_back(16'h0003);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL r5_mem: got %h expected %h", SrcData1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (SrcData2 !== e) begin n_fail++; $display("FAIL r6_pc: got %h expected %h", SrcData2, e); end
        e = exp_q.pop_front(); n_checks++;
        if (write_count !== e) begin n_fail++; $display("FAIL count_r0_skip: got %h expected %h", write_count, e); end
        SrcReg1 = 4'd0;
        exp_q.push_back(16'h0000);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL r0_read: got %h expected %h", SrcData1, e); end
    endtask

    task automatic test_bubble;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 16'h7777, 16'h7777, 16'h7777, 4'd9, 4'd9, 4'd9);
        exp_q.push_back(16'h0000);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({15'd0, WriteEn} !== e) begin n_fail++; $display("FAIL bubble_wen: got %h expected %h", WriteEn, e); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd9, 4'd9);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0003);
        exp_q.push_back(16'h0000);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL bubble_r9: got %h expected %h", SrcData1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (write_count !== e) begin n_fail++; $display("FAIL bubble_count: got %h expected %h", write_count, e); end
        e = exp_q.pop_front(); n_checks++;
        if ({15'd0, halted} !== e) begin n_fail++; $display("FAIL bubble_halted: got %h expected %h", halted, e); end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 16'hA0A0, 16'h0, 16'h0, 4'd10, 4'd10, 4'd10);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 16'h0B0B, 16'h0, 16'h0, 4'd11, 4'd10, 4'd11);
        exp_q.push_back(16'hA0A0);
        exp_q.push_back(16'h0B0B);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL b2b_stored: got %h expected %h", SrcData1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (SrcData2 !== e) begin n_fail++; $display("FAIL b2b_bypass: got %h expected %h", SrcData2, e); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd11, 4'd3);
        exp_q.push_back(16'h0B0B);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h0005);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL b2b_r11: got %h expected %h", SrcData1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (SrcData2 !== e) begin n_fail++; $display("FAIL b2b_r3_kept: got %h expected %h", SrcData2, e); end
        e = exp_q.pop_front(); n_checks++;
        if (write_count !== e) begin n_fail++; $display("FAIL b2b_count: got %h expected %h", write_count, e); end
    endtask

    task automatic test_halt;
        @(posedge clk); #1;
        drive(1, 0, 0, 1, 16'h5555, 16'h0, 16'h0, 4'd7, 4'd7, 4'd7);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({15'd0, WriteEn} !== e) begin n_fail++; $display("FAIL halt_wen: got %h expected %h", WriteEn, e); end
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL halt_no_bypass: got %h expected %h", SrcData1, e); end
        e = exp_q.pop_front(); n_checks++;
        if ({15'd0, halted} !== e) begin n_fail++; $display("FAIL halt_not_yet: got %h expected %h", halted, e); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(1, 0, 0, 1'(i == 1), 16'h8888, 16'h0, 16'h0, 4'd8, 4'd8, 4'd7);
            exp_q.push_back(16'h0001);
            exp_q.push_back(16'h0000);
            @(negedge clk);
            e = exp_q.pop_front(); n_checks++;
            if ({15'd0, halted} !== e) begin n_fail++; $display("FAIL halted_%0d: got %h expected %h", i, halted, e); end
            e = exp_q.pop_front(); n_checks++;
            if ({15'd0, WriteEn} !== e) begin n_fail++; $display("FAIL halted_wen_%0d: got %h expected %h", i, WriteEn, e); end
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd8, 4'd5);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'h0005);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL halted_r8: got %h expected %h", SrcData1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (SrcData2 !== e) begin n_fail++; $display("FAIL halted_r5_read: got %h expected %h", SrcData2, e); end
        e = exp_q.pop_front(); n_checks++;
        if (write_count !== e) begin n_fail++; $display("FAIL halted_count: got %h expected %h", write_count, e); end
        SrcReg1 = 4'd7;
        exp_q.push_back(16'h0000);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL halt_r7: got %h expected %h", SrcData1, e); end
    endtask

    task automatic test_reset_from_halt;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1, 0, 0, 0, 16'h1234, 16'h0, 16'h0, 4'd2, 4'd0, 4'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd5, 4'd2);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({15'd0, halted} !== e) begin n_fail++; $display("FAIL rst_halted: got %h expected %h", halted, e); end
        e = exp_q.pop_front(); n_checks++;
        if (write_count !== e) begin n_fail++; $display("FAIL rst_count: got %h expected %h", write_count, e); end
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL rst_r5: got %h expected %h", SrcData1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (SrcData2 !== e) begin n_fail++; $display("FAIL rst_r2_prio: got %h expected %h", SrcData2, e); end
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 16'h00AA, 16'h0, 16'h0, 4'd2, 4'd0, 4'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd2, 4'd0);
        exp_q.push_back(16'h00AA);
        exp_q.push_back(16'h0001);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL post_rst_r2: got %h expected %h", SrcData1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (write_count !== e) begin n_fail++; $display("FAIL post_rst_count: got %h expected %h", write_count, e); end
    endtask

    task automatic test_wrap;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            drive(1, 0, 0, 0, 16'(i), 16'h0, 16'h0, 4'((i % 15) + 1), 4'd0, 4'd0);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd15, 4'd0);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'hFFFE);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (write_count !== e) begin n_fail++; $display("FAIL wrap_preload: got %h expected %h", write_count, e); end
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL wrap_last_r15: got %h expected %h", SrcData1, e); end
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 16'hC0DE, 16'h0, 16'h0, 4'd1, 4'd0, 4'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd1, 4'd0);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hC0DE);
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if (write_count !== e) begin n_fail++; $display("FAIL wrap_to_zero: got %h expected %h", write_count, e); end
        e = exp_q.pop_front(); n_checks++;
        if (SrcData1 !== e) begin n_fail++; $display("FAIL wrap_r1: got %h expected %h", SrcData1, e); end
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0);
        test_reset;
        test_bypass;
        test_source_select;
        test_bubble;
        test_back_to_back;
        test_halt;
        test_reset_from_halt;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side consumer of the MEM/WB pipeline register for the 16-bit pipelined CPU. Takes the registered WB control bits, ALU result, data-memory word, destination register and forwarded PC, selects the writeback value and commits it into a 16 x 16-bit register file. It serves the two decode-stage read ports with same-cycle write bypass. It also latches the processor halt and counts committed register writes for the testbench.

## Interface
Parameters: none (widths fixed by the ISA: 16-bit data, 4-bit register index).
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-low
- RegWrite  input  1  WB control: commit a register write this cycle
- MemtoReg  input  1  WB control: write data comes from dmem_in
- PCtoReg  input  1  WB control: write data comes from PC_in (PCS)
- Halt  input  1  WB control: HLT instruction reaches writeback
- reg_data_in  input  16  ALU result from MEM/WB
- dmem_in  input  16  data-memory word from MEM/WB
- DstReg_in  input  4  destination register index
- PC_in  input  16  forwarded PC value for PCS
- SrcReg1, SrcReg2  input  4  decode-stage read indices
- SrcData1, SrcData2  output  16  read data (combinational, bypassed)
- WriteData  output  16  selected writeback value (combinational)
- WriteEn  output  1  effective write enable this cycle (combinational)
- halted  output  1  registered; processor has retired HLT
- write_count  output  16  registered count of committed writes

## Operation
- WriteData select, priority: PCtoReg -> PC_in; else MemtoReg -> dmem_in; else reg_data_in.
- WriteEn = RegWrite & ~Halt & ~halted & (DstReg_in != 0).
- On rising edge with rst=1 and WriteEn=1: regs[DstReg_in] <= WriteData; write_count <= write_count + 1 (mod 2^16, wraps 0xFFFF -> 0x0000).
- R0 hardwired zero: never written, always reads 0x0000, never bypassed.
- Read port n: SrcRegn==0 -> 0x0000; else if WriteEn and DstReg_in==SrcRegn -> WriteData (bypass); else regs[SrcRegn]. Both ports bypass independently and may read the same register.
- All-zero WB bits (bubble from a nop flush) produce no write, no count, no halt.
- Halt state machine, two states:
  - RUN: halted=0. Halt=1 sampled -> HALTED. A write on the same cycle as Halt is suppressed (HLT never writes).
  - HALTED: halted=1. All writes blocked, write_count frozen, reads still served from stored contents. Leaves only on reset.
- Reset (rst=0 at edge): all regs R1-R15 <= 0x0000, write_count <= 0, state <= RUN. Reset has priority over any simultaneous write or Halt.

## Timing
- Write latency: value visible at SrcData via bypass in the same cycle as the write; from the stored array starting the cycle after the edge.
- halted rises the cycle after Halt is sampled high. Halt held high for multiple cycles has no further effect.
- Reset values: halted=0, write_count=0x0000, SrcData1/2=0x0000 for any index.
- WriteData/WriteEn/SrcData are combinational from inputs and state. They are never registered here.
- Reset asserted while in HALTED returns to RUN on that edge. Writes are accepted on the first edge with rst=1.

## Test plan
- Reset, then read all 16 indices -> all 0x0000; halted=0; write_count=0.
- RegWrite=1, DstReg_in=3, reg_data_in=0x1234, SrcReg1=3 same cycle -> SrcData1=0x1234 (bypass). Next cycle with RegWrite=0 -> SrcData1=0x1234; write_count=1.
- Source select: MemtoReg=1, dmem_in=0xBEEF -> R5=0xBEEF. Then PCtoReg=1, MemtoReg=1, PC_in=0x0042 -> R6=0x0042 (PC wins). Then DstReg_in=0, data 0xFFFF -> R0 reads 0, count unchanged.
- Halt=1 with RegWrite=1, DstReg_in=7, data 0x5555 -> R7 unchanged, halted=1 next cycle. Further writes to R8 are ignored and write_count is frozen.
- Preload write_count to 0xFFFF via 65535 writes, then one more write -> write_count=0x0000.
- While halted, pulse rst=0 for one edge -> halted=0, regs zero. Next write R2=0x00AA succeeds.
